spi16_master_mode3: RTL and testbench

- Single-transaction SPI master that shifts one 16-bit word out on MOSI while simultaneously capturing 16 bits from MISO.
- Uses SPI mode 3: SCLK idles high, MOSI changes on the SCLK falling edge, MISO is sampled on the rising edge, MSB first.
- Sits between the register-access controller and an ADXL345-class accelerometer.
- The 16-bit word is transferred as two bytes, with a short SCLK-high gap between them.

---
 rtl/spi16_master_mode3_if.sv | 21 ++
 rtl/spi16_master_mode3.sv | 130 +++++++++++++
 tb/tb_spi16_master_mode3.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi16_master_mode3_if.sv
// Register-controller <-> SPI master bundle, including the serial pins toward the accelerometer.
interface spi16_master_mode3_if;
    logic [15:0] data_in_16bit;
    logic        start;
    logic        MISO;
    logic        busy;
    logic [15:0] data_out_16bit;
    logic        CS;
    logic        MOSI;
    logic        SCLK;

    modport master (
        input  data_in_16bit, start, MISO,
        output busy, data_out_16bit, CS, MOSI, SCLK
    );

    modport slave (
        output data_in_16bit, start, MISO,
        input  busy, data_out_16bit, CS, MOSI, SCLK
    );
endinterface

// File: rtl/spi16_master_mode3.sv
// SPI mode-3 master: one 16-bit full-duplex word per transaction, sent as two bytes
// with a widened SCLK-high gap between them. All outputs come straight from flops.
module spi16_master_mode3 #(
    parameter int CLK_DIV  = 11,
    parameter int BYTE_GAP = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi16_master_mode3_if.master  bus
);
    localparam int MAX_CNT = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLK_DIV - 1);
    // A zero gap still costs one clock in GAP; the byte boundary is never seamless.
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      tx_sr;
    logic [15:0]      rx_sr;
    logic             busy_r;
    logic             cs_r;
    logic             mosi_r;
    logic             sclk_r;
    logic [15:0]      dout_r;

    assign bus.busy           = busy_r;
    assign bus.CS             = cs_r;
    assign bus.MOSI           = mosi_r;
    assign bus.SCLK           = sclk_r;
    assign bus.data_out_16bit = dout_r;

    // The port keeps its legacy name but is an active-high asynchronous reset.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            busy_r  <= 1'b0;
            cs_r    <= 1'b1;
            mosi_r  <= 1'b0;
            sclk_r  <= 1'b1;
            dout_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr   <= bus.data_in_16bit;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        cnt     <= HALF_LD;
                        busy_r  <= 1'b1;
                        cs_r    <= 1'b0;
                        mosi_r  <= bus.data_in_16bit[15];
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        cnt    <= HALF_LD;
                        sclk_r <= 1'b0;
                        state  <= LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOW: begin
                    // The rising SCLK edge and the MISO sample share this clock edge.
                    if (cnt == '0) begin
                        cnt    <= HALF_LD;
                        sclk_r <= 1'b1;
                        rx_sr  <= {rx_sr[14:0], bus.MISO};
                        state  <= HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        if (bit_cnt == 4'd7) begin
                            cnt   <= GAP_LD;
                            state <= GAP;
                        end else if (bit_cnt == 4'd15) begin
                            cnt   <= HALF_LD;
                            state <= HOLD;
                        end else begin
                            cnt     <= HALF_LD;
                            bit_cnt <= bit_cnt + 4'd1;
                            tx_sr   <= {tx_sr[14:0], 1'b0};
                            mosi_r  <= tx_sr[14];
                            sclk_r  <= 1'b0;
                            state   <= LOW;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        cnt     <= HALF_LD;
                        bit_cnt <= bit_cnt + 4'd1;
                        tx_sr   <= {tx_sr[14:0], 1'b0};
                        mosi_r  <= tx_sr[14];
                        sclk_r  <= 1'b0;
                        state   <= LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cs_r   <= 1'b1;
                        mosi_r <= 1'b0;
                        busy_r <= 1'b0;
                        dout_r <= rx_sr;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi16_master_mode3.sv
// Directed bench for spi16_master_mode3: a slave model drives MISO and records MOSI/SCLK edge times.
`timescale 1ns/1ps
module tb_spi16_master_mode3;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    spi16_master_mode3_if bus();

    spi16_master_mode3 #(.CLK_DIV(11), .BYTE_GAP(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] miso_pat = 16'h0000;
    int          miso_idx = 0;
    logic [15:0] mosi_cap = 16'h0000;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          idle_fall = 0;
    time         rise_t [16];
    time         fall_t [16];
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;

    // Slave model: reload MISO on CS falling, shift MOSI in and advance MISO on SCLK rising.
    always @(bus.CS or bus.SCLK) begin
        if (prev_cs === 1'b1 && bus.CS === 1'b0) begin
            rise_cnt = 0;
            fall_cnt = 0;
            mosi_cap = 16'h0000;
            bus.MISO = miso_pat[15];
            miso_idx = 14;
        end
        if (prev_sclk === 1'b0 && bus.SCLK === 1'b1 && bus.CS === 1'b0) begin
            if (rise_cnt < 16) rise_t[rise_cnt] = $time;
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], bus.MOSI};
            if (miso_idx >= 0) begin
                bus.MISO = miso_pat[miso_idx];
                miso_idx--;
            end
        end
        if (prev_sclk === 1'b1 && bus.SCLK === 1'b0) begin
            if (bus.CS !== 1'b0) idle_fall++;
            else begin
                if (fall_cnt < 16) fall_t[fall_cnt] = $time;
                fall_cnt++;
            end
        end
        prev_cs = bus.CS;
        prev_sclk = bus.SCLK;
    end

    task automatic do_xfer(input logic [15:0] tx, input logic [15:0] mi, input int hold,
                           input bit poke, output int nclk, output logic acc_ok,
                           output logic hold_ok, output logic [15:0] old_out);
        @(negedge clk);
        old_out = bus.data_out_16bit;
        miso_pat = mi;
        bus.data_in_16bit = tx;
        bus.start = 1'b1;
        @(posedge clk); #1;
        acc_ok = (bus.busy === 1'b1 && bus.CS === 1'b0 && bus.MOSI === tx[15]);
        hold_ok = 1'b1;
        nclk = 0;
        while (nclk < 1000) begin
            @(posedge clk); nclk++; #1;
            if (nclk == hold) bus.start = 1'b0;
            if (poke && nclk == 150) begin
                bus.start = 1'b1;
                bus.data_in_16bit = ~tx;
            end
            if (poke && nclk == 170) bus.start = 1'b0;
            if (bus.busy !== 1'b1) break;
            if (bus.data_out_16bit !== old_out) hold_ok = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.data_in_16bit = 16'h0000;
        reset_n = 1'b1;
        #100;
        tests++; if (bus.CS !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b want 1", bus.CS); end
        tests++; if (bus.SCLK !== 1'b1) begin fails++; $display("FAIL reset_sclk: got %b want 1", bus.SCLK); end
        tests++; if (bus.MOSI !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", bus.MOSI); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.data_out_16bit !== 16'h0000) begin fails++; $display("FAIL reset_dout: got %h want 0000", bus.data_out_16bit); end
        @(negedge clk);
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.CS !== 1'b1) begin fails++; $display("FAIL idle_no_start: busy=%b cs=%b want busy=0 cs=1", bus.busy, bus.CS); end
    endtask

    task automatic test_basic();
        int n; logic acc, hok; logic [15:0] old;
        do_xfer(16'h7D55, 16'hE7E7, 15, 1'b0, n, acc, hok, old);
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL basic_accept: got %b want 1", acc); end
        tests++; if (n != 382) begin fails++; $display("FAIL basic_len: got %0d want 382", n); end
        tests++; if (bus.CS !== 1'b1 || bus.MOSI !== 1'b0) begin fails++; $display("FAIL basic_end_pins: cs=%b mosi=%b want 1 0", bus.CS, bus.MOSI); end
        tests++; if (bus.data_out_16bit !== 16'hE7E7) begin fails++; $display("FAIL basic_dout: got %h want e7e7", bus.data_out_16bit); end
        tests++; if (mosi_cap !== 16'h7D55) begin fails++; $display("FAIL basic_mosi: got %h want 7d55", mosi_cap); end
        tests++; if (rise_cnt != 16 || fall_cnt != 16) begin fails++; $display("FAIL basic_edges: rise=%0d fall=%0d want 16 16", rise_cnt, fall_cnt); end
        tests++; if (rise_t[1] - rise_t[0] != 220) begin fails++; $display("FAIL basic_period: got %0t want 220", rise_t[1] - rise_t[0]); end
        tests++; if (fall_t[8] - rise_t[7] != 190) begin fails++; $display("FAIL basic_gap_high: got %0t want 190", fall_t[8] - rise_t[7]); end
        tests++; if (rise_t[15] - rise_t[8] != 1540) begin fails++; $display("FAIL basic_byte2_span: got %0t want 1540", rise_t[15] - rise_t[8]); end
        tests++; if (hok !== 1'b1) begin fails++; $display("FAIL basic_dout_hold: changed mid-transfer, want stable 0000"); end
    endtask

    task automatic test_second();
        int n; logic acc, hok; logic [15:0] old;
        do_xfer(16'hF0F0, 16'hAAAA, 15, 1'b0, n, acc, hok, old);
        tests++; if (old !== 16'hE7E7 || hok !== 1'b1) begin fails++; $display("FAIL second_dout_hold: start=%h stable=%b want e7e7 1", old, hok); end
        tests++; if (mosi_cap !== 16'hF0F0) begin fails++; $display("FAIL second_mosi: got %h want f0f0", mosi_cap); end
        tests++; if (bus.data_out_16bit !== 16'hAAAA) begin fails++; $display("FAIL second_dout: got %h want aaaa", bus.data_out_16bit); end
        tests++; if (n != 382) begin fails++; $display("FAIL second_len: got %0d want 382", n); end
    endtask

    task automatic test_ignore_start();
        int n; logic acc, hok; logic [15:0] old;
        do_xfer(16'h3C5A, 16'h9669, 15, 1'b1, n, acc, hok, old);
        tests++; if (n != 382) begin fails++; $display("FAIL ignore_len: got %0d want 382", n); end
        tests++; if (rise_cnt != 16) begin fails++; $display("FAIL ignore_edges: got %0d want 16", rise_cnt); end
        tests++; if (mosi_cap !== 16'h3C5A) begin fails++; $display("FAIL ignore_mosi: got %h want 3c5a", mosi_cap); end
        tests++; if (bus.data_out_16bit !== 16'h9669) begin fails++; $display("FAIL ignore_dout: got %h want 9669", bus.data_out_16bit); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_no_restart: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int n; logic acc, hok; logic [15:0] old;
        int w;
        @(negedge clk);
        miso_pat = 16'hFFFF;
        bus.data_in_16bit = 16'hA5C3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        w = 0;
        while (rise_cnt < 5 && w < 500) begin
            @(posedge clk); #1; w++;
        end
        tests++; if (rise_cnt < 5) begin fails++; $display("FAIL midreset_wait: rises=%0d want 5 within 500 clocks", rise_cnt); end
        @(negedge clk); #2;
        reset_n = 1'b1;
        #1;
        tests++; if (bus.CS !== 1'b1 || bus.SCLK !== 1'b1) begin fails++; $display("FAIL midreset_pins: cs=%b sclk=%b want 1 1", bus.CS, bus.SCLK); end
        tests++; if (bus.busy !== 1'b0 || bus.MOSI !== 1'b0) begin fails++; $display("FAIL midreset_busy: busy=%b mosi=%b want 0 0", bus.busy, bus.MOSI); end
        tests++; if (bus.data_out_16bit !== 16'h0000) begin fails++; $display("FAIL midreset_dout: got %h want 0000", bus.data_out_16bit); end
        @(negedge clk);
        reset_n = 1'b0;
        do_xfer(16'h1234, 16'h5678, 15, 1'b0, n, acc, hok, old);
        tests++; if (mosi_cap !== 16'h1234) begin fails++; $display("FAIL after_reset_mosi: got %h want 1234", mosi_cap); end
        tests++; if (bus.data_out_16bit !== 16'h5678) begin fails++; $display("FAIL after_reset_dout: got %h want 5678", bus.data_out_16bit); end
        tests++; if (n != 382) begin fails++; $display("FAIL after_reset_len: got %0d want 382", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] cap1;
        @(negedge clk);
        miso_pat = 16'hC3C3;
        bus.data_in_16bit = 16'h0FF0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (n < 1000) begin
            @(posedge clk); n++; #1;
            if (bus.busy !== 1'b1) break;
        end
        cap1 = mosi_cap;
        tests++; if (n != 382) begin fails++; $display("FAIL b2b_len1: got %0d want 382", n); end
        tests++; if (bus.CS !== 1'b1) begin fails++; $display("FAIL b2b_cs_gap: got %b want 1", bus.CS); end
        tests++; if (bus.data_out_16bit !== 16'hC3C3 || cap1 !== 16'h0FF0) begin fails++; $display("FAIL b2b_data1: dout=%h mosi=%h want c3c3 0ff0", bus.data_out_16bit, cap1); end
        bus.data_in_16bit = 16'h8001;
        miso_pat = 16'h5AA5;
        @(posedge clk); #1;
        tests++; if (bus.busy !== 1'b1 || bus.CS !== 1'b0) begin fails++; $display("FAIL b2b_restart: busy=%b cs=%b want 1 0", bus.busy, bus.CS); end
        bus.start = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(posedge clk); n++; #1;
            if (bus.busy !== 1'b1) break;
        end
        tests++; if (n != 382) begin fails++; $display("FAIL b2b_len2: got %0d want 382", n); end
        tests++; if (bus.data_out_16bit !== 16'h5AA5 || mosi_cap !== 16'h8001) begin fails++; $display("FAIL b2b_data2: dout=%h mosi=%h want 5aa5 8001", bus.data_out_16bit, mosi_cap); end
        tests++; if (idle_fall != 0) begin fails++; $display("FAIL sclk_while_cs_high: got %0d falls want 0", idle_fall); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
